// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx round-robin arbiter.
// Used by uart_tx_arbiter and uart_rr_pick.
package uart_arb_pkg;

    localparam int ARB_MAX_REQ = 8;
    localparam int BYTE_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2
    } arb_state_e;

    // Width of an index into n requesters; never below 1 bit.
    function automatic int arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority encoder: returns the first set request found when
// scanning ptr, ptr+1, ... modulo N_REQ. Purely combinational so it can be
// shared by other schedulers (e.g. an rx-side one).
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]            req,
    input  logic [arb_idx_w(N_REQ)-1:0] ptr,
    output logic                        valid,
    output logic [arb_idx_w(N_REQ)-1:0] idx
);

    localparam int IDW = arb_idx_w(N_REQ);

    int             cand;
    logic [IDW-1:0] cand_idx;

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        valid    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = int'(ptr) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDW'(cand);
            if (req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among N_REQ byte requesters.
// Latches the winner's byte, drives the uart_tx data/write_en/rdy handshake
// and acks the requester once uart_tx has taken the byte.
// Optional watchdog: define UART_ARB_TIMEOUT_EN to abort a frame stuck in
// LAUNCH or BUSY for TIMEOUT cycles (err_timeout pulses, no ack).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no frame in flight; arbitrate when uart_tx is ready
// ST_LAUNCH | wr_en high with latched byte, waiting for uart_tx to accept
// ST_BUSY   | byte accepted and acked; waiting for uart_tx to go idle
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [BYTE_W*N_REQ-1:0]     req_data,
    output logic [N_REQ-1:0]            ack,
    output logic [arb_idx_w(N_REQ)-1:0] grant_id,
    output logic                        busy,
    output logic                        err_timeout,
    output logic [BYTE_W-1:0]           uart_data,
    output logic                        uart_wr_en,
    input  logic                        uart_rdy
);

    localparam int             IDW      = arb_idx_w(N_REQ);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    if (N_REQ < 2 || N_REQ > ARB_MAX_REQ || TIMEOUT < 2) begin : g_bad_cfg
        $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT at least 2");
    end

    arb_state_e        state_q;
    logic [IDW-1:0]    ptr_q;
    logic [IDW-1:0]    grant_q;
    logic [N_REQ-1:0]  ack_q;
    logic              busy_q;
    logic [BYTE_W-1:0] data_q;
    logic              wr_en_q;

    logic              win_valid;
    logic [IDW-1:0]    win_idx;
    logic [BYTE_W-1:0] win_data_d;
    logic [IDW-1:0]    next_ptr_d;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int             WDW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LOAD = WDW'(TIMEOUT - 1);

    logic [WDW-1:0] wd_cnt_q;
    logic           err_q;
`endif

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // Byte of the current arbitration winner.
    always_comb begin
        win_data_d = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_idx == IDW'(k)) begin
                win_data_d = req_data[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // Pointer value that puts the requester after the current grant on top.
    always_comb begin
        if (grant_q == LAST_IDX) begin
            next_ptr_d = '0;
        end else begin
            next_ptr_d = grant_q + 1'b1;
        end
    end

    // Arbitration FSM with registered handshake, ack and status outputs.
    // BUSY shares the IDLE grant path so a new frame can launch in the same
    // cycle uart_tx reports idle again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
            data_q   <= '0;
            wr_en_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            unique case (state_q)
                ST_IDLE, ST_BUSY: begin
                    if (uart_rdy) begin
                        if (win_valid) begin
                            data_q   <= win_data_d;
                            grant_q  <= win_idx;
                            wr_en_q  <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= ST_LAUNCH;
`ifdef UART_ARB_TIMEOUT_EN
                            wd_cnt_q <= WD_LOAD;
`endif
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (state_q == ST_BUSY) begin
                        if (wd_cnt_q == '0) begin
                            err_q   <= 1'b1;
                            ptr_q   <= next_ptr_d;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            wd_cnt_q <= wd_cnt_q - 1'b1;
                        end
                    end
`endif
                end
                ST_LAUNCH: begin
                    if (!uart_rdy) begin
                        wr_en_q  <= 1'b0;
                        ack_q    <= ONE_HOT0 << grant_q;
                        ptr_q    <= next_ptr_d;
                        state_q  <= ST_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                        wd_cnt_q <= WD_LOAD;
`endif
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (wd_cnt_q == '0) begin
                        wr_en_q <= 1'b0;
                        err_q   <= 1'b1;
                        ptr_q   <= next_ptr_d;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q - 1'b1;
                    end
`endif
                end
                default: begin
                    wr_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack        = ack_q;
    assign grant_id   = grant_q;
    assign busy       = busy_q;
    assign uart_data  = data_q;
    assign uart_wr_en = wr_en_q;

`ifdef UART_ARB_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uart_tx model with serial decoder,
// per-requester byte queues and a round-robin reference model feeding an
// ack scoreboard and a serial-byte scoreboard.
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int TMO  = 16;
    localparam int BITC = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [8*N-1:0] req_data;
    logic [N-1:0] ack;
    logic [1:0]   grant_id;
    logic         busy;
    logic         err_timeout;
    logic [7:0]   uart_data;
    logic         uart_wr_en;
    logic         uart_rdy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_timeout (err_timeout),
        .uart_data   (uart_data),
        .uart_wr_en  (uart_wr_en),
        .uart_rdy    (uart_rdy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- uart_tx model ----------------
    logic       rdy_m;
    logic       tx;
    logic       stuck = 1'b0;
    logic [9:0] frame;
    int         bitn;
    int         tick;

    assign uart_rdy = stuck | rdy_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_m <= 1'b1;
            tx    <= 1'b1;
            frame <= '1;
            bitn  <= 0;
            tick  <= 0;
        end else if (rdy_m) begin
            if (uart_wr_en && !stuck) begin
                frame <= {1'b1, uart_data, 1'b0};
                tx    <= 1'b0;
                rdy_m <= 1'b0;
                bitn  <= 0;
                tick  <= 0;
            end
        end else if (tick == BITC - 1) begin
            tick <= 0;
            if (bitn == 9) begin
                rdy_m <= 1'b1;
                tx    <= 1'b1;
            end else begin
                bitn <= bitn + 1;
                tx   <= frame[bitn+1];
            end
        end else begin
            tick <= tick + 1;
        end
    end

    // ---------------- requesters and reference model ----------------
    logic [7:0] bq    [N][$];
    logic [7:0] stage [N][$];
    int         exp_ack [$];
    logic [7:0] exp_byte [$];
    int         model_ptr = 0;
    bit         err_ok = 1'b0;

    // Requester k asserts req while it has bytes queued; the head byte is
    // presented and dropped once its ack arrives.
    initial begin
        req      = '0;
        req_data = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (rst_n && ack[k] && bq[k].size() > 0) void'(bq[k].pop_front());
                req[k] = (bq[k].size() > 0);
                req_data[8*k +: 8] = req[k] ? bq[k][0] : 8'h00;
            end
        end
    end

    // Round-robin over pending byte counts: the first requester with bytes
    // left, scanning from the pointer, wins; the pointer then moves past it.
    task automatic commit();
        int rem [N];
        int pos [N];
        int left = 0;
        int k;
        for (int i = 0; i < N; i++) begin
            rem[i] = stage[i].size();
            pos[i] = 0;
            left  += rem[i];
        end
        while (left > 0) begin
            for (int off = 0; off < N; off++) begin
                k = (model_ptr + off) % N;
                if (rem[k] > 0) begin
                    exp_ack.push_back(k);
                    exp_byte.push_back(stage[k][pos[k]]);
                    pos[k]++;
                    rem[k]--;
                    left--;
                    model_ptr = (k + 1) % N;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            foreach (stage[i][j]) bq[i].push_back(stage[i][j]);
            stage[i].delete();
        end
    endtask

    // ---------------- monitors ----------------
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (rst_n && ack !== '0) begin
                if (exp_ack.size() == 0) begin
                    chk("ack_unexpected", 32'(ack), 32'h0);
                end else begin
                    e = exp_ack.pop_front();
                    chk("ack_idx", 32'(ack), 32'(1) << e);
                    chk("ack_grant_id", 32'(grant_id), 32'(e));
                end
            end
            if (rst_n && err_timeout && !err_ok) chk("err_unexpected", 32'(err_timeout), 32'h0);
        end
    end

    initial begin
        logic [7:0] d;
        logic       stp;
        logic [7:0] eb;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                repeat (BITC + 1) @(negedge clk);
                d[0] = tx;
                for (int i = 1; i < 8; i++) begin
                    repeat (BITC) @(negedge clk);
                    d[i] = tx;
                end
                repeat (BITC) @(negedge clk);
                stp = tx;
                chk("frame_stop_bit", 32'(stp), 32'h1);
                if (exp_byte.size() == 0) begin
                    chk("frame_unexpected", 32'(d), 32'h0);
                end else begin
                    eb = exp_byte.pop_front();
                    chk("frame_byte", 32'(d), 32'(eb));
                end
            end
        end
    end

    task automatic drain(input string tag);
        int i;
        for (i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (exp_ack.size() == 0 && exp_byte.size() == 0 && !busy && uart_rdy) break;
        end
        if (i == 5000) chk({tag, "_drain_timeout"}, 32'h0, 32'h1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_wr(input string tag);
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (uart_wr_en) break;
        end
        if (i == 200) chk({tag, "_wr_en_timeout"}, 32'h0, 32'h1);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] mask;
        int         n;
        rst_n = 1'b0;

        // Reset with every requester asking.
        for (int k = 0; k < N; k++) stage[k].push_back(8'hC0 + 8'(k));
        commit();
        repeat (3) begin
            @(negedge clk);
            chk("rst_ack", 32'(ack), 32'h0);
            chk("rst_grant_id", 32'(grant_id), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_err", 32'(err_timeout), 32'h0);
            chk("rst_uart_data", 32'(uart_data), 32'h0);
            chk("rst_wr_en", 32'(uart_wr_en), 32'h0);
            chk("rst_tx_idle", 32'(tx), 32'h1);
        end
        rst_n = 1'b1;
        wait_wr("first");
        chk("first_grant_id", 32'(grant_id), 32'h0);
        chk("first_uart_data", 32'(uart_data), 32'hC0);
        drain("reset");

        // All four continuously requesting: 11,22,33,44,11.
        stage[0].push_back(8'h11);
        stage[0].push_back(8'h11);
        stage[1].push_back(8'h22);
        stage[2].push_back(8'h33);
        stage[3].push_back(8'h44);
        commit();
        drain("rr");

        // Grant 1 alone, then 0 and 1 together: 0 wins by wrap, then 1.
        stage[1].push_back(8'h66);
        commit();
        drain("skip_a");
        stage[0].push_back(8'h67);
        stage[1].push_back(8'h68);
        commit();
        drain("skip_b");

        // Single requester: wr_en one cycle after the arbitration edge.
        stage[2].push_back(8'hA5);
        commit();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            if (req[2]) break;
        end
        @(negedge clk);
        chk("single_wr_en_latency", 32'(uart_wr_en), 32'h1);
        chk("single_grant_id", 32'(grant_id), 32'h2);
        chk("single_uart_data", 32'(uart_data), 32'hA5);
        drain("single");

        // Reset while wr_en is up: byte lost, no ack, request re-granted.
        stage[2].push_back(8'h5A);
        commit();
        wait_wr("midrst");
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(uart_wr_en), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_ack", 32'(ack), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drain("midrst");

        // Random rounds of 1..3 bytes per requester.
        for (int r = 0; r < 8; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int k = 0; k < N; k++) begin
                if (mask[k]) begin
                    n = $urandom_range(1, 3);
                    repeat (n) stage[k].push_back(8'($urandom));
                end
            end
            commit();
            drain("random");
        end

`ifdef UART_ARB_TIMEOUT_EN
        begin
            int w;
            int o;
            int cnt;
            w = 1;
            for (int off = 0; off < N; off++) begin
                if ((model_ptr + off) % N == 1 || (model_ptr + off) % N == 3) begin
                    w = (model_ptr + off) % N;
                    break;
                end
            end
            o = (w == 1) ? 3 : 1;
            exp_ack.push_back(o);
            exp_byte.push_back(8'h70 + 8'(o));
            exp_ack.push_back(w);
            exp_byte.push_back(8'h70 + 8'(w));
            model_ptr = (w + 1) % N;
            stuck  = 1'b1;
            err_ok = 1'b1;
            bq[1].push_back(8'h71);
            bq[3].push_back(8'h73);
            wait_wr("tmo");
            chk("tmo_grant_id", 32'(grant_id), 32'(w));
            cnt = 1;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (err_timeout) break;
                if (uart_wr_en) cnt++;
            end
            chk("tmo_launch_cycles", 32'(cnt), 32'(TMO));
            chk("tmo_err_pulse", 32'(err_timeout), 32'h1);
            chk("tmo_wr_en_dropped", 32'(uart_wr_en), 32'h0);
            chk("tmo_idle", 32'(busy), 32'h0);
            chk("tmo_no_ack", 32'(ack), 32'h0);
            stuck = 1'b0;
            @(negedge clk);
            chk("tmo_err_width", 32'(err_timeout), 32'h0);
            chk("tmo_next_wr_en", 32'(uart_wr_en), 32'h1);
            chk("tmo_next_grant", 32'(grant_id), 32'(o));
            err_ok = 1'b0;
            drain("tmo");
        end
`endif

        chk("ack_queue_empty", 32'(exp_ack.size()), 32'h0);
        chk("byte_queue_empty", 32'(exp_byte.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
